// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: bus bundle for the WS2812-style receiver.
//   din        serial NRZ line into the receiver
//   data       last latched pixel word
//   data_valid one-cycle pulse when data updates
//   frame_err  one-cycle pulse when an incomplete frame is discarded
//   dout       regenerated serial line towards the next device
// The slave modport is the receiver side; the master modport is whoever
// drives the line and consumes the decoded result.
interface ws2812_rx_if #(
  parameter int unsigned BITS_PER_LED = 24
) ();

  logic                    din;
  logic [BITS_PER_LED-1:0] data;
  logic                    data_valid;
  logic                    frame_err;
  logic                    dout;

  modport master (
    output din,
    input  data,
    input  data_valid,
    input  frame_err,
    input  dout
  );

  modport slave (
    input  din,
    output data,
    output data_valid,
    output frame_err,
    output dout
  );

endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: single-wire WS2812-style NRZ receiver.
// Captures the first BITS_PER_LED bits of each frame (MSB first), forwards all
// later bits on dout with a 3-cycle din->dout latency, and latches the captured
// word on the low latch gap.
// Ports:
//   clk     system clock
//   nreset  synchronous active-low reset
//   bus     ws2812_rx_if.slave (din in; data, data_valid, frame_err, dout out)
module ws2812_rx #(
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned BIT_THRESH   = 6,
  parameter int unsigned RESET_CYCLES = 500
) (
  input  logic         clk,
  input  logic         nreset,
  ws2812_rx_if.slave   bus
);

  localparam int unsigned CW  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned BCW = $clog2(BITS_PER_LED + 1);

  localparam logic [CW-1:0]  GAP_MAX  = CW'(RESET_CYCLES);
  localparam logic [CW-1:0]  GAP_PRE  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]  HIGH_MAX = '1;
  localparam logic [CW-1:0]  THRESH   = CW'(BIT_THRESH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS_PER_LED - 1);

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    RX,
    PASS
  } state_t;

  state_t                  state;
  logic                    sync1;
  logic                    din_s;
  logic                    din_q;
  logic [CW-1:0]           low_cnt;
  logic [CW-1:0]           high_cnt;
  logic [BCW-1:0]          bit_cnt;
  logic [BITS_PER_LED-1:0] shreg;
  logic [BITS_PER_LED-1:0] data;
  logic                    data_valid;
  logic                    frame_err;
  logic                    dout;

  logic rise;
  logic fall;
  logic gap;
  logic bit_val;

  // Edge detect against the registered copy of the synchronized line.
  assign rise    = din_s & ~din_q;
  assign fall    = ~din_s & din_q;
  // Gap is the single cycle in which low_cnt reaches RESET_CYCLES.
  assign gap     = ~din_s && (low_cnt == GAP_PRE);
  // high_cnt equals the synchronized high width at the falling edge.
  assign bit_val = (high_cnt >= THRESH);

  // Synchronizer, counters and receive state machine.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= WAIT_GAP;
      sync1      <= 1'b0;
      din_s      <= 1'b0;
      din_q      <= 1'b0;
      low_cnt    <= '0;
      high_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      dout       <= 1'b0;
    end else begin
      sync1 <= bus.din;
      din_s <= sync1;
      din_q <= din_s;

      if (din_s) begin
        low_cnt <= '0;
      end else if (low_cnt != GAP_MAX) begin
        low_cnt <= low_cnt + 1'b1;
      end

      // The rising-edge cycle already counts as the first high cycle.
      if (rise) begin
        high_cnt <= CW'(1);
      end else if (din_s && (high_cnt != HIGH_MAX)) begin
        high_cnt <= high_cnt + 1'b1;
      end

      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      dout       <= 1'b0;

      case (state)
        // Stay deaf until a full gap so we never lock on mid-stream.
        WAIT_GAP: begin
          if (gap) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (rise) begin
            state <= RX;
          end
        end
        RX: begin
          if (fall) begin
            shreg   <= {shreg[BITS_PER_LED-2:0], bit_val};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= PASS;
            end
          end else if (gap) begin
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        PASS: begin
          dout <= din_s;
          if (gap) begin
            data       <= shreg;
            data_valid <= 1'b1;
            bit_cnt    <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= WAIT_GAP;
        end
      endcase
    end
  end

  assign bus.data       = data;
  assign bus.data_valid = data_valid;
  assign bus.frame_err  = frame_err;
  assign bus.dout       = dout;

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812-style NRZ receiver; the LED-side end of the protocol our rgbled driver transmits.
- Decodes the first BITS_PER_LED bits of each frame into a pixel word and regenerates all later bits on dout for the next device in the chain.
- Latches the pixel word on the reset/latch gap.
- Used as an on-chip loopback checker for the LED driver and as a cascadable pixel input.

Parameters:
- BITS_PER_LED, 24: bits captured per frame, MSB first.
- BIT_THRESH, 6: high-time threshold in clk cycles; high time >= BIT_THRESH decodes as 1, otherwise 0.
- RESET_CYCLES, 500: consecutive low cycles that form the latch/reset gap (50 us at 10 MHz).

Ports:
- clk  input  1  system clock.
- nreset  input  1  synchronous active-low reset.
- din  input  1  asynchronous serial NRZ input.
- data  output  BITS_PER_LED  last latched pixel word.
- data_valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  one-cycle pulse when an incomplete frame is discarded.
- dout  output  1  regenerated downstream serial output.

Behaviour:
- Reset: one clock, synchronous, active-low. The reset is sampled only on the rising clk edge while nreset=0.
  - Reset values: data=0, data_valid=0, frame_err=0, dout=0, shift register=0, bit_cnt=0, counters=0, state=WAIT_GAP.
  - Reset mid-operation discards any partial frame and leaves data=0.
- Input path:
  - din passes through a 2-FF synchronizer to produce din_s.
  - Rising and falling edges are detected against a registered copy of din_s.
- low_cnt:
  - Increments every cycle din_s=0 and clears when din_s=1.
  - Saturates at RESET_CYCLES. "Gap" means the cycle in which low_cnt reaches RESET_CYCLES; it fires once per low period.
- high_cnt:
  - Clears on a rising edge and increments while din_s=1.
  - Saturates at 2^W-1, where W=$clog2(RESET_CYCLES+1).
- States:
  - WAIT_GAP: ignores all edges. Gap -> IDLE. This prevents locking mid-stream after reset.
  - IDLE: rising edge -> RX.
  - RX:
    - On each falling edge, decode bit = (high_cnt >= BIT_THRESH), shift it into shreg (MSB first), bit_cnt++.
    - When bit_cnt reaches BITS_PER_LED -> PASS.
    - Gap with 0 < bit_cnt < BITS_PER_LED: assert frame_err for 1 cycle, leave data unchanged, clear bit_cnt -> IDLE.
  - PASS:
    - dout follows din_s, registered once. Total din->dout latency is 3 cycles, so high widths are preserved exactly.
    - Gap: data <= shreg, assert data_valid for 1 cycle, clear bit_cnt -> IDLE.
- dout is 0 in every state except PASS. The captured bits are never forwarded.
- data holds its value between gaps and changes only together with data_valid.
- data_valid and frame_err are mutually exclusive and never asserted on consecutive cycles from a single gap.
- A gap in IDLE (no bits received) produces no pulse.
- A high time that saturates high_cnt decodes as 1. No other error is flagged.

Test Plan (10 MHz, defaults; encoding for 0 = 4 high/8 low cycles, encoding for 1 = 8 high/4 low cycles):
- Reset, 500 low cycles, then 24 bits of 0xFF0080, then 500 low cycles -> data=0xFF0080; data_valid high exactly 1 cycle, 500 cycles after the synchronized last falling edge; dout stays 0.
- After the gap, 48 bits (0x123456 then 0xABCDEF), then gap -> data=0x123456; dout reproduces the 0xABCDEF waveform with identical high/low widths, delayed 3 cycles from din.
- After the gap, 10 bits, then gap -> frame_err pulses once; data keeps its previous value; the next full frame 0x00FF00 decodes correctly.
- Threshold sweep: bits with high time 5 vs 6 cycles (period 12) -> decoded 0 vs 1; frame 24 bits alternating 5/6 -> data=0x555555.
- Reset released while din toggles a continuous bitstream with no gap -> no data_valid and no dout activity until 500 low cycles occur; the subsequent frame decodes normally.
- nreset asserted for 1 cycle after bit 12 of a frame -> all outputs 0, state WAIT_GAP; the remaining bits are ignored; no pulses at the following gap.
